// File: rtl/pm_min_search_ctrl.sv
// Best-path-metric search: streams the PM store beat by beat, reduces each beat with the
// modulo compare and folds the winner into a running best that seeds traceback.
module pm_min_search_ctrl #(
  parameter int PM_W         = 8,
  parameter int NUM_STATES   = 64,
  parameter int PMS_PER_BEAT = 8,
  parameter int IDX_W        = 6,
  parameter int ADDR_W       = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  output logic                         pm_rd_req,
  output logic [ADDR_W-1:0]            pm_rd_addr,
  input  logic                         pm_rd_valid,
  input  logic [PM_W*PMS_PER_BEAT-1:0] pm_rd_data,
  output logic                         busy,
  output logic                         done,
  output logic [IDX_W-1:0]             best_idx,
  output logic [PM_W-1:0]              best_pm,
  output logic                         proto_err
);

  localparam int NUM_BEATS = NUM_STATES / PMS_PER_BEAT;
  localparam int LANE_SH   = $clog2(PMS_PER_BEAT);
  localparam int LANE_W    = (LANE_SH > 0) ? LANE_SH : 1;
  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(NUM_BEATS - 1);
  localparam logic [IDX_W-1:0]  MAX_IDX   = IDX_W'(NUM_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DONE} state_t;

  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic [PM_W-1:0]   pm;
  } cand_t;

  // Modulo compare: 1 keeps a, 0 (including ties) takes b.
  function automatic logic pm_win(input logic [PM_W-1:0] a, input logic [PM_W-1:0] b);
    return a[PM_W-1] ^ b[PM_W-1] ^ (a[PM_W-2:0] < b[PM_W-2:0]);
  endfunction

  // Heap-ordered tree: leaves sit at PMS_PER_BEAT+lane, so node 2i always holds the lower lanes.
  function automatic cand_t beat_reduce(input logic [PM_W*PMS_PER_BEAT-1:0] data);
    logic [PM_W-1:0]   node_pm [2*PMS_PER_BEAT];
    logic [LANE_W-1:0] node_ln [2*PMS_PER_BEAT];
    cand_t             res;
    node_pm[0] = '0;
    node_ln[0] = '0;
    for (int k = 0; k < PMS_PER_BEAT; k++) begin
      node_pm[PMS_PER_BEAT+k] = data[k*PM_W +: PM_W];
      node_ln[PMS_PER_BEAT+k] = LANE_W'(k);
    end
    for (int i = PMS_PER_BEAT - 1; i >= 1; i--) begin
      if (pm_win(node_pm[2*i], node_pm[2*i+1])) begin
        node_pm[i] = node_pm[2*i];
        node_ln[i] = node_ln[2*i];
      end else begin
        node_pm[i] = node_pm[2*i+1];
        node_ln[i] = node_ln[2*i+1];
      end
    end
    res.lane = node_ln[1];
    res.pm   = node_pm[1];
    return res;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   beat_q, beat_d;
  logic [PM_W-1:0]     run_pm_q, run_pm_d;
  logic [IDX_W-1:0]    run_pos_q, run_pos_d;
  logic                pm_rd_req_q, pm_rd_req_d;
  logic [ADDR_W-1:0]   pm_rd_addr_q, pm_rd_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [IDX_W-1:0]    best_idx_q, best_idx_d;
  logic [PM_W-1:0]     best_pm_q, best_pm_d;
  logic                proto_err_q, proto_err_d;

  cand_t               beat_win;
  logic [IDX_W-1:0]    beat_pos;
  logic                fold_keep;
  logic [PM_W-1:0]     fold_pm;
  logic [IDX_W-1:0]    fold_pos;

  // Running best is tracked by stream position; the state index is derived only at the end.
  always_comb begin
    beat_win  = beat_reduce(pm_rd_data);
    beat_pos  = (IDX_W'(beat_q) << LANE_SH) | IDX_W'(beat_win.lane);
    fold_keep = (beat_q != '0) && pm_win(run_pm_q, beat_win.pm);
    fold_pm   = fold_keep ? run_pm_q  : beat_win.pm;
    fold_pos  = fold_keep ? run_pos_q : beat_pos;
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    run_pm_d     = run_pm_q;
    run_pos_d    = run_pos_q;
    pm_rd_req_d  = 1'b0;
    pm_rd_addr_d = pm_rd_addr_q;
    done_d       = 1'b0;
    best_idx_d   = best_idx_q;
    best_pm_d    = best_pm_q;
    proto_err_d  = proto_err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_FETCH;
          beat_d       = '0;
          proto_err_d  = 1'b0;
          pm_rd_req_d  = 1'b1;
          pm_rd_addr_d = '0;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pm_rd_valid) begin
          run_pm_d  = fold_pm;
          run_pos_d = fold_pos;
          if (beat_q == LAST_BEAT) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            best_idx_d = MAX_IDX - fold_pos;
            best_pm_d  = fold_pm;
          end else begin
            state_d      = S_FETCH;
            beat_d       = beat_q + ADDR_W'(1);
            pm_rd_req_d  = 1'b1;
            pm_rd_addr_d = beat_q + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort cancels everything this cycle would have started or published.
    if (abort) begin
      state_d      = S_IDLE;
      beat_d       = beat_q;
      run_pm_d     = run_pm_q;
      run_pos_d    = run_pos_q;
      pm_rd_req_d  = 1'b0;
      pm_rd_addr_d = pm_rd_addr_q;
      done_d       = 1'b0;
      best_idx_d   = best_idx_q;
      best_pm_d    = best_pm_q;
      proto_err_d  = proto_err_q;
    end

    if (pm_rd_valid && (state_q != S_WAIT)) begin
      proto_err_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      run_pm_q     <= '0;
      run_pos_q    <= '0;
      pm_rd_req_q  <= 1'b0;
      pm_rd_addr_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      best_idx_q   <= '0;
      best_pm_q    <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      run_pm_q     <= run_pm_d;
      run_pos_q    <= run_pos_d;
      pm_rd_req_q  <= pm_rd_req_d;
      pm_rd_addr_q <= pm_rd_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      best_idx_q   <= best_idx_d;
      best_pm_q    <= best_pm_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign pm_rd_req  = pm_rd_req_q;
  assign pm_rd_addr = pm_rd_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign best_idx   = best_idx_q;
  assign best_pm    = best_pm_q;
  assign proto_err  = proto_err_q;

endmodule
